serial_tl_host: RTL and testbench



---
 rtl/serial_tl_pkg.sv | 21 ++
 rtl/serial_tl_rx_fifo.sv | 60 ++++++
 rtl/serial_tl_host.sv | 109 ++++++++++
 tb/tb_serial_tl_host.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_tl_pkg.sv
// Shared definitions for the host-side serial_tl endpoint: default word width,
// TX state encoding and a constant-evaluable clog2.
package serial_tl_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [0:0] TX_IDLE  = 1'b0;
    localparam logic [0:0] TX_SHIFT = 1'b1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/serial_tl_rx_fifo.sv
// Synchronous word FIFO for deserialized RX words; head is a flop read so data
// falls through the cycle after the push. Pops on an empty FIFO are dropped.
module serial_tl_rx_fifo
    import serial_tl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PW = clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/serial_tl_host.sv
// Host-side serial_tl endpoint: serializes host words onto bits_in (LSB first)
// and deserializes bits_out into a small word FIFO, all on the chip's clock.
module serial_tl_host
    import serial_tl_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int RX_DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [WIDTH-1:0] tx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             serial_tl_bits_in_valid,
    input  logic             serial_tl_bits_in_ready,
    output logic             serial_tl_bits_in_bits,
    input  logic             serial_tl_bits_out_valid,
    output logic             serial_tl_bits_out_ready,
    input  logic             serial_tl_bits_out_bits,
    output logic             tx_busy
);

    localparam int CNT_W = clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    // Every channel here, word or bit, moves one item on a rising edge where
    // valid && ready; a valid source holds its data until that edge.

    logic [0:0]       tx_state;
    logic [WIDTH-1:0] tx_shreg;
    logic [CNT_W-1:0] tx_cnt;

    // TX outputs decode straight from flops so nothing combinational reaches the pins.
    assign tx_ready                = (tx_state == TX_IDLE);
    assign tx_busy                 = (tx_state == TX_SHIFT);
    assign serial_tl_bits_in_valid = (tx_state == TX_SHIFT);
    assign serial_tl_bits_in_bits  = tx_shreg[0];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_state <= TX_IDLE;
            tx_shreg <= '0;
            tx_cnt   <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (tx_valid) begin
                        tx_shreg <= tx_data;
                        tx_cnt   <= '0;
                        tx_state <= TX_SHIFT;
                    end
                end
                TX_SHIFT: begin
                    if (serial_tl_bits_in_ready) begin
                        tx_shreg <= tx_shreg >> 1;
                        tx_cnt   <= tx_cnt + 1'b1;
                        if (tx_cnt == LAST_BIT) begin
                            tx_state <= TX_IDLE;
                        end
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // Only the upper WIDTH-1 bits need storing; the final bit joins on the push.
    logic [WIDTH-2:0] rx_shreg;
    logic [CNT_W-1:0] rx_cnt;
    logic [WIDTH-1:0] rx_word;
    logic             rx_xfer;
    logic             rx_word_done;
    logic             fifo_full;
    logic             fifo_empty;

    assign serial_tl_bits_out_ready = !fifo_full;
    assign rx_valid                 = !fifo_empty;
    assign rx_xfer                  = serial_tl_bits_out_valid && serial_tl_bits_out_ready;
    assign rx_word                  = {serial_tl_bits_out_bits, rx_shreg};
    assign rx_word_done             = rx_xfer && (rx_cnt == LAST_BIT);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_shreg <= '0;
            rx_cnt   <= '0;
        end else if (rx_xfer) begin
            rx_shreg <= rx_word[WIDTH-1:1];
            rx_cnt   <= rx_cnt + 1'b1;
        end
    end

    serial_tl_rx_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (rx_word_done),
        .push_data (rx_word),
        .pop       (rx_ready),
        .head      (rx_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_serial_tl_host.sv
// Bench for serial_tl_host: bit-queue reference model checked every cycle,
// directed link scenarios with literal expectations, then a randomized run.
module tb_serial_tl_host;

    localparam int W = 32;
    localparam int D = 2;

    // ---------------- clock / reset ----------------
    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic         tx_valid = 1'b0;
    logic         tx_ready;
    logic [W-1:0] tx_data  = '0;
    logic         rx_valid;
    logic         rx_ready;
    logic [W-1:0] rx_data;
    logic         in_valid;
    logic         in_ready;
    logic         in_bits;
    logic         out_valid = 1'b0;
    logic         out_ready;
    logic         out_bits  = 1'b0;
    logic         tx_busy;

    logic rand_mode    = 1'b0;
    logic in_ready_cmd = 1'b1;
    logic in_ready_rnd = 1'b1;
    logic rx_ready_cmd = 1'b1;
    logic rx_ready_rnd = 1'b1;
    assign in_ready = rand_mode ? in_ready_rnd : in_ready_cmd;
    assign rx_ready = rand_mode ? rx_ready_rnd : rx_ready_cmd;

    serial_tl_host #(.WIDTH(W), .RX_DEPTH(D)) dut (
        .clock                    (clock),
        .reset_n                  (reset_n),
        .tx_valid                 (tx_valid),
        .tx_ready                 (tx_ready),
        .tx_data                  (tx_data),
        .rx_valid                 (rx_valid),
        .rx_ready                 (rx_ready),
        .rx_data                  (rx_data),
        .serial_tl_bits_in_valid  (in_valid),
        .serial_tl_bits_in_ready  (in_ready),
        .serial_tl_bits_in_bits   (in_bits),
        .serial_tl_bits_out_valid (out_valid),
        .serial_tl_bits_out_ready (out_ready),
        .serial_tl_bits_out_bits  (out_bits),
        .tx_busy                  (tx_busy)
    );

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;
    int unsigned cyc    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    logic [W-1:0] host_q[$];
    logic         chip_q[$];
    bit           tx_acc  = 1'b0;
    bit           rx_fire = 1'b0;

    task automatic send_tx(input logic [W-1:0] word);
        host_q.push_back(word);
    endtask

    task automatic send_rx(input logic [W-1:0] word);
        for (int i = 0; i < W; i++) chip_q.push_back(word[i]);
    endtask

    always @(posedge clock) begin
        #1;
        if (tx_acc && host_q.size() > 0) void'(host_q.pop_front());
        if (rx_fire && chip_q.size() > 0) void'(chip_q.pop_front());
        tx_valid     = (host_q.size() > 0) && (!rand_mode || $urandom_range(0, 3) != 0);
        tx_data      = (host_q.size() > 0) ? host_q[0] : W'($urandom);
        out_valid    = (chip_q.size() > 0) && (!rand_mode || $urandom_range(0, 3) != 0);
        out_bits     = (chip_q.size() > 0) ? chip_q[0] : 1'b0;
        in_ready_rnd = ($urandom_range(0, 3) != 0);
        rx_ready_rnd = ($urandom_range(0, 2) != 0);
    end

    // ---------------- reference model + scoreboard ----------------
    logic         m_tx_bits[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_rx_acc = '0;
    int           m_rx_n   = 0;
    bit           m_pop, m_push;

    logic [W-1:0] tx_coll = '0;
    int           tx_cnt  = 0;
    logic [W-1:0] tx_got_q[$];
    logic [W-1:0] rx_got_q[$];
    int           rx_bit_cnt = 0;
    int           last_bit_cyc = 0, first_valid_cyc = 0, rx_valid_cycles = 0;
    logic         prev_rx_valid = 1'b0;
    int           vrun = 0, grun = 0;
    bit           seen = 1'b0;
    int           run_q[$];
    int           gap_q[$];

    always @(negedge clock) begin
        cyc++;
        if (!reset_n) begin
            m_tx_bits.delete();
            exp_q.delete();
            m_rx_acc   = '0;
            m_rx_n     = 0;
            tx_cnt     = 0;
            rx_bit_cnt = 0;
        end
        chk("tx_ready", tx_ready, m_tx_bits.size() == 0);
        chk("tx_busy", tx_busy, m_tx_bits.size() != 0);
        chk("in_valid", in_valid, m_tx_bits.size() != 0);
        if (m_tx_bits.size() != 0) chk("in_bits", in_bits, m_tx_bits[0]);
        else if (!reset_n) chk("in_bits_rst", in_bits, 0);
        chk("out_ready", out_ready, exp_q.size() < D);
        chk("rx_valid", rx_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) chk("rx_data", rx_data, exp_q[0]);
        else if (!reset_n) chk("rx_data_rst", rx_data, 0);

        tx_acc  = tx_valid && tx_ready;
        rx_fire = out_valid && out_ready;
        if (reset_n) begin
            if (in_valid && in_ready) begin
                tx_coll = {in_bits, tx_coll[W-1:1]};
                tx_cnt++;
                if (tx_cnt == W) begin
                    tx_got_q.push_back(tx_coll);
                    tx_cnt = 0;
                end
            end
            if (rx_fire) begin
                rx_bit_cnt++;
                if (rx_bit_cnt == W) begin
                    last_bit_cyc = cyc;
                    rx_bit_cnt   = 0;
                end
            end
            if (rx_valid && rx_ready) rx_got_q.push_back(rx_data);
        end
        if (rx_valid && !prev_rx_valid) first_valid_cyc = cyc;
        if (rx_valid) rx_valid_cycles++;
        prev_rx_valid = rx_valid;
        if (in_valid) begin
            vrun++;
            if (grun > 0 && seen) gap_q.push_back(grun);
            grun = 0;
            seen = 1'b1;
        end else begin
            if (vrun > 0) run_q.push_back(vrun);
            vrun = 0;
            if (seen) grun++;
        end

        if (reset_n) begin
            if (m_tx_bits.size() != 0) begin
                if (in_ready) void'(m_tx_bits.pop_front());
            end else if (tx_valid) begin
                for (int i = 0; i < W; i++) m_tx_bits.push_back(tx_data[i]);
            end
            m_pop  = rx_ready && exp_q.size() != 0;
            m_push = out_valid && exp_q.size() < D;
            if (m_pop) void'(exp_q.pop_front());
            if (m_push) begin
                m_rx_acc = {out_bits, m_rx_acc[W-1:1]};
                m_rx_n++;
                if (m_rx_n == W) begin
                    exp_q.push_back(m_rx_acc);
                    m_rx_n = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic clear_logs();
        run_q.delete();
        gap_q.delete();
        tx_got_q.delete();
        rx_got_q.delete();
        vrun = 0;
        grun = 0;
        seen = 1'b0;
        rx_valid_cycles = 0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int i;
        i = 0;
        while (i < budget && !(host_q.size() == 0 && chip_q.size() == 0 && !tx_busy &&
                               !tx_valid && !rx_valid && rx_bit_cnt == 0)) begin
            step();
            i++;
        end
        repeat (3) step();
        chk(name, i < budget, 1);
    endtask

    logic [W-1:0] exp_tx_q[$];
    logic [W-1:0] exp_rx_q[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish by 1ms");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int i;
        logic [W-1:0] w;

        repeat (3) @(posedge clock);
        @(negedge clock); #1;
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_in_valid", in_valid, 0);
        chk("rst_in_bits", in_bits, 0);
        chk("rst_tx_busy", tx_busy, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_out_ready", out_ready, 1);
        step();
        reset_n = 1'b1;
        step();

        // back-to-back TX words, chip always ready
        clear_logs();
        send_tx(32'hA5A5_0001);
        send_tx(32'h0F0F_3C3C);
        wait_idle("t1_idle", 400);
        chk("t1_runs", run_q.size(), 2);
        chk("t1_run0", run_q[0], 32);
        chk("t1_run1", run_q[1], 32);
        chk("t1_gap", gap_q[0], 1);
        chk("t1_word0", tx_got_q[0], 32'hA5A5_0001);
        chk("t1_word1", tx_got_q[1], 32'h0F0F_3C3C);

        // stall on bit 7
        clear_logs();
        send_tx(32'h0000_0080);
        i = 0;
        while (i < 100 && tx_cnt != 7) begin step(); i++; end
        chk("t2_reach_bit7", tx_cnt, 7);
        in_ready_cmd = 1'b0;
        repeat (5) begin
            @(negedge clock); #1;
            chk("t2_hold", in_bits, 1);
            step();
        end
        in_ready_cmd = 1'b1;
        wait_idle("t2_idle", 200);
        chk("t2_run", run_q[0], 37);
        chk("t2_word", tx_got_q[0], 32'h0000_0080);

        // single RX word
        clear_logs();
        send_rx(32'hDEAD_BEEF);
        wait_idle("t3_idle", 200);
        chk("t3_count", rx_got_q.size(), 1);
        chk("t3_word", rx_got_q[0], 32'hDEAD_BEEF);
        chk("t3_latency", first_valid_cyc - last_bit_cyc, 1);
        chk("t3_pulse", rx_valid_cycles, 1);

        // RX backpressure with three words
        clear_logs();
        rx_ready_cmd = 1'b0;
        send_rx(32'h1111_2222);
        send_rx(32'h3333_4444);
        send_rx(32'h5555_6666);
        i = 0;
        while (i < 200 && chip_q.size() != 32) begin step(); i++; end
        repeat (5) step();
        chk("t4_stall_bit0", chip_q.size(), 32);
        chk("t4_out_ready", out_ready, 0);
        chk("t4_none_popped", rx_got_q.size(), 0);
        rx_ready_cmd = 1'b1;
        wait_idle("t4_idle", 300);
        chk("t4_count", rx_got_q.size(), 3);
        chk("t4_w0", rx_got_q[0], 32'h1111_2222);
        chk("t4_w1", rx_got_q[1], 32'h3333_4444);
        chk("t4_w2", rx_got_q[2], 32'h5555_6666);

        // pop on the same edge the next word completes
        clear_logs();
        rx_ready_cmd = 1'b0;
        send_rx(32'hAAAA_0001);
        send_rx(32'hBBBB_0002);
        i = 0;
        while (i < 200 && chip_q.size() != 1) begin step(); i++; end
        chk("t5_reach_last", chip_q.size(), 1);
        rx_ready_cmd = 1'b1;
        @(negedge clock);
        @(negedge clock); #1;
        chk("t5_valid", rx_valid, 1);
        chk("t5_head", rx_data, 32'hBBBB_0002);
        chk("t5_out_ready", out_ready, 1);
        chk("t5_first", rx_got_q[0], 32'hAAAA_0001);
        wait_idle("t5_idle", 100);
        chk("t5_count", rx_got_q.size(), 2);

        // reset mid-word in both directions
        clear_logs();
        send_rx(32'hCAFE_F00D);
        repeat (9) step();
        send_tx(32'h5A5A_C3C3);
        i = 0;
        while (i < 200 && tx_cnt != 10) begin step(); i++; end
        chk("t6_reach_bit10", tx_cnt, 10);
        reset_n = 1'b0;
        host_q.delete();
        chip_q.delete();
        @(negedge clock); #1;
        chk("t6_in_valid", in_valid, 0);
        chk("t6_out_ready", out_ready, 1);
        chk("t6_rx_valid", rx_valid, 0);
        repeat (2) step();
        reset_n = 1'b1;
        step();
        clear_logs();
        send_tx(32'h1234_5678);
        send_rx(32'h1234_5678);
        wait_idle("t6_idle", 200);
        chk("t6_tx_count", tx_got_q.size(), 1);
        chk("t6_tx_word", tx_got_q[0], 32'h1234_5678);
        chk("t6_rx_count", rx_got_q.size(), 1);
        chk("t6_rx_word", rx_got_q[0], 32'h1234_5678);

        // randomized traffic with random stalls on every handshake
        clear_logs();
        rand_mode = 1'b1;
        for (int k = 0; k < 16; k++) begin
            w = W'($urandom);
            exp_tx_q.push_back(w);
            send_tx(w);
            w = W'($urandom);
            exp_rx_q.push_back(w);
            send_rx(w);
        end
        wait_idle("rand_idle", 20000);
        rand_mode = 1'b0;
        chk("rand_tx_count", tx_got_q.size(), exp_tx_q.size());
        chk("rand_rx_count", rx_got_q.size(), exp_rx_q.size());
        for (int k = 0; k < exp_tx_q.size(); k++) chk("rand_tx_word", tx_got_q[k], exp_tx_q[k]);
        for (int k = 0; k < exp_rx_q.size(); k++) chk("rand_rx_word", rx_got_q[k], exp_rx_q[k]);

        repeat (2) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
